// File: rtl/even_odd_pkg.sv
// Shared types and constants for the even_odd arbiter slice.
// Holds the FSM state encoding, the default data width and the
// helper that sizes requester index fields.
package even_odd_pkg;

    localparam int DEFAULT_W    = 32;
    localparam int DEFAULT_NREQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    // Index width for n requesters; never narrower than one bit.
    function automatic int id_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEFAULT_ID_W = id_w(DEFAULT_NREQ);

endpackage

// File: rtl/even_odd_rr_pick.sv
// Combinational round-robin picker.
// Finds the first set bit of req, searching upward from ptr and wrapping
// past NREQ-1 back to 0. Returns it one-hot (gnt), encoded (idx), and
// whether any request was present at all (any).
module even_odd_rr_pick
    import even_odd_pkg::*;
#(
    parameter int NREQ = DEFAULT_NREQ,
    localparam int IW  = id_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    // Walk the offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        int          j;
        logic [IW-1:0] j_idx;
        j     = 0;
        j_idx = '0;
        idx   = '0;
        any   = |req;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j     = (int'(ptr) + k) % NREQ;
            j_idx = IW'(j);
            if (req[j_idx]) begin
                idx = j_idx;
            end
        end
        gnt = any ? (NREQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/even_odd_arbiter.sv
// Round-robin arbiter/sequencer sharing one even_odd core among NREQ clients.
// Grants one request at a time, runs the core's ap_ctrl_hs handshake,
// captures ap_return and hands it back on a valid/ready response channel.
// Optional watchdog: define EVEN_ODD_ARB_TIMEOUT_EN to abort a core run
// after TIMEOUT_CYC cycles with rsp_err=1 and rsp_data=0.
//
// Handshakes: a request transfers on the rising edge where req_valid[i] and
// req_ready[i] are both high; a response transfers on the rising edge where
// rsp_valid and rsp_ready are both high. A raised valid is held, with its
// payload stable, until that transfer edge.
module even_odd_arbiter
    import even_odd_pkg::*;
#(
    parameter int NREQ        = DEFAULT_NREQ,
    parameter int W           = DEFAULT_W,
    parameter int TIMEOUT_CYC = 1024,
    localparam int IW         = id_w(NREQ)
) (
    input  logic            ap_clk,
    input  logic            ap_rst_n,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] req_ready,
    input  logic [NREQ*W-1:0] req_s,
    input  logic [NREQ*W-1:0] req_e,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [IW-1:0]   rsp_id,
    output logic [W-1:0]    rsp_data,
    output logic            rsp_err,
    output logic            core_start,
    output logic [W-1:0]    core_s,
    output logic [W-1:0]    core_e,
    input  logic            core_ready,
    input  logic            core_done,
    input  logic            core_idle,
    input  logic [W-1:0]    core_return,
    output logic            busy,
    output logic [1:0]      dbg_state
);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] START = ST_START;
    localparam logic [1:0] WAIT  = ST_WAIT;
    localparam logic [1:0] RESP  = ST_RESP;

    logic [1:0]      state;
    logic [IW-1:0]   rr_ptr;
    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic            grant_ok;
    logic            core_fin;
    logic            timeout_fire;
    logic            rsp_take;

    even_odd_rr_pick #(.NREQ(NREQ)) u_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // A grant needs a waiting request, an idle FSM and an idle core.
    assign grant_ok = (state == IDLE) && pick_any && core_idle;
    // In START the result only counts once the core has taken the start.
    assign core_fin = ((state == START) && core_ready && core_done) ||
                      ((state == WAIT) && core_done);
    assign rsp_take = (state == RESP) && rsp_ready;

    // Accept is combinational; gated with reset so every output reads 0 in reset.
    assign req_ready  = grant_ok && ap_rst_n ? pick_gnt : '0;
    assign core_start = (state == START);
    assign rsp_valid  = (state == RESP);
    assign busy       = (state != IDLE);
    assign dbg_state  = state;

`ifdef EVEN_ODD_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] wd_cnt;
    logic          err_q;

    assign timeout_fire = ((state == START) || (state == WAIT)) && !core_fin &&
                          (wd_cnt == CW'(TIMEOUT_CYC - 1));
    assign rsp_err      = err_q;

    // Watchdog: restarts on each grant, counts every cycle spent on the core.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wd_cnt <= '0;
        end else if (grant_ok) begin
            wd_cnt <= '0;
        end else if ((state == START) || (state == WAIT)) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // Error flag raised by a watchdog abort, dropped when the response is taken.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            err_q <= 1'b0;
        end else if (timeout_fire) begin
            err_q <= 1'b1;
        end else if (rsp_take) begin
            err_q <= 1'b0;
        end
    end
`else
    assign timeout_fire = 1'b0;
    assign rsp_err      = 1'b0;
`endif

    // Sequencer: IDLE -> START -> (WAIT) -> RESP -> IDLE.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (grant_ok) state <= START;
                START: begin
                    if (core_fin || timeout_fire) state <= RESP;
                    else if (core_ready)          state <= WAIT;
                end
                WAIT:    if (core_fin || timeout_fire) state <= RESP;
                RESP:    if (rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Operands and owner id are latched on the grant and held until the next one.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            core_s <= '0;
            core_e <= '0;
            rsp_id <= '0;
        end else if (grant_ok) begin
            core_s <= req_s[pick_idx*W +: W];
            core_e <= req_e[pick_idx*W +: W];
            rsp_id <= pick_idx;
        end
    end

    // Result capture; a watchdog abort returns zero.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rsp_data <= '0;
        end else if (core_fin) begin
            rsp_data <= core_return;
        end else if (timeout_fire) begin
            rsp_data <= '0;
        end
    end

    // Fairness pointer: the requester after the one just served goes first next.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rr_ptr <= '0;
        end else if (rsp_take) begin
            rr_ptr <= (rsp_id == IW'(NREQ - 1)) ? '0 : rsp_id + 1'b1;
        end
    end

endmodule

// File: tb/tb_even_odd_arbiter.sv
// Bench for even_odd_arbiter: core stub computing s^e, directed scenarios
// followed by randomized traffic against a round-robin reference model.
module tb_even_odd_arbiter;
  import even_odd_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int TO   = 16;
  localparam int IW   = 2;

  // ---------------- clock / reset ----------------
  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_s = '0;
  logic [NREQ*W-1:0] req_e = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [IW-1:0]     rsp_id;
  logic [W-1:0]      rsp_data;
  logic              rsp_err;
  logic              core_start;
  logic [W-1:0]      core_s;
  logic [W-1:0]      core_e;
  logic              core_ready;
  logic              core_done;
  logic              core_idle;
  logic [W-1:0]      core_return;
  logic              busy;
  logic [1:0]        dbg_state;

  even_odd_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT_CYC(TO)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_s(req_s), .req_e(req_e),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .core_start(core_start), .core_s(core_s), .core_e(core_e),
    .core_ready(core_ready), .core_done(core_done), .core_idle(core_idle),
    .core_return(core_return), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- core stub ----------------
  // Latency mode: accepts start at once, done stub_lat cycles later.
  // Zero mode: ready and done in the same cycle as start.
  // Hang mode: never finishes and stays non-idle until released.
  int          stub_lat  = 3;
  bit          stub_zero = 1'b0;
  bit          stub_hang = 1'b0;
  logic        stub_run;
  int          stub_cnt;
  logic [W-1:0] stub_res;

  assign core_ready  = core_start & ~stub_run;
  assign core_done   = stub_zero ? (core_start & ~stub_run)
                                 : (stub_run && (stub_cnt == 0) && !stub_hang);
  assign core_return = stub_zero ? (core_s ^ core_e) : stub_res;
  assign core_idle   = ~stub_run;

  always @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      stub_run <= 1'b0;
      stub_cnt <= 0;
      stub_res <= '0;
    end else if (!stub_run) begin
      if (core_start && !stub_zero) begin
        stub_run <= 1'b1;
        stub_cnt <= stub_lat - 1;
        stub_res <= core_s ^ core_e;
      end
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
    end else if (!stub_hang) begin
      stub_run <= 1'b0;
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int total = 0;
  int bad   = 0;
  int model_ptr = 0;
  int grant_cnt [NREQ];
  int refresh_mode = 0;  // 0 hold request, 1 drop granted, 2 random refresh
  logic [W-1:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first valid requester at or after ptr, wrapping.
  function automatic int model_pick(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge ap_clk);
    #2;
  endtask

  task automatic set_req(input int i, input bit v);
    req_valid[i]        = v;
    req_s[i*W +: W]     = $urandom;
    req_e[i*W +: W]     = $urandom;
  endtask

  task automatic refresh_after_grant(input int g);
    if (refresh_mode == 1) begin
      req_valid[g] = 1'b0;
    end else if (refresh_mode == 2) begin
      set_req(g, 1'($urandom_range(0, 1)));
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) set_req(i, 1'b1);
      end
      if (req_valid == '0) set_req($urandom_range(0, NREQ - 1), 1'b1);
    end
  endtask

  // One full transaction: grant, core run, response with optional hold-off.
  task automatic run_txn(input int rsp_delay, input bit tie_ready);
    int g, lat, exp_lat;
    bit got, prev_done;
    logic [W-1:0] exp_d;
    #1;
    rsp_ready = tie_ready;
    g = model_pick(req_valid, model_ptr);
    if (g < 0) begin
      bad++;
      $error("FAIL no_request observed=none expected=some");
      return;
    end
    exp_d   = req_s[g*W +: W] ^ req_e[g*W +: W];
    exp_lat = stub_zero ? 1 : stub_lat + 1;
    exp_q.push_back(exp_d);
    got = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (req_ready != '0) begin got = 1'b1; break; end
      step();
    end
    check("grant_seen", got, 1'b1);
    if (!got) return;
    check("grant_onehot", req_ready, NREQ'(1) << g);
    step();
    check("start_cycle1", core_start, 1'b1);
    check("core_s", core_s, req_s[g*W +: W]);
    check("core_e", core_e, req_e[g*W +: W]);
    check("ready_low_busy", req_ready, '0);
    refresh_after_grant(g);
    prev_done = core_done;
    lat = 0;
    got = 1'b0;
    for (int n = 0; n < 60; n++) begin
      step();
      lat++;
      if (rsp_valid) begin got = 1'b1; break; end
      check("start_single", core_start, 1'b0);
      prev_done = core_done;
    end
    check("rsp_seen", got, 1'b1);
    if (!got) return;
    exp_d = exp_q.pop_front();
    check("done_then_rsp", prev_done, 1'b1);
    check("rsp_latency", lat, exp_lat);
    check("rsp_id", rsp_id, g);
    check("rsp_data", rsp_data, exp_d);
    check("rsp_err_clear", rsp_err, 1'b0);
    for (int n = 0; n < rsp_delay; n++) begin
      step();
      check("hold_valid", rsp_valid, 1'b1);
      check("hold_data", rsp_data, exp_d);
      check("hold_no_grant", req_ready, '0);
      check("hold_no_start", core_start, 1'b0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = tie_ready;
    model_ptr = (g + 1) % NREQ;
    grant_cnt[g]++;
    check("rsp_done_valid", rsp_valid, 1'b0);
  endtask

  // ---------------- global bound ----------------
  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    bit got;
    for (int i = 0; i < NREQ; i++) grant_cnt[i] = 0;

    // Reset state, with requests already asserted.
    req_valid = '1;
    #12;
    check("rst_req_ready", req_ready, '0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_id", rsp_id, '0);
    check("rst_rsp_data", rsp_data, '0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_core_start", core_start, 1'b0);
    check("rst_core_s", core_s, '0);
    check("rst_core_e", core_e, '0);
    check("rst_busy", busy, 1'b0);

    // Single request from 0: 0xF0 ^ 0x0F.
    req_valid = 4'b0001;
    req_s[0 +: W] = 32'h0000_00F0;
    req_e[0 +: W] = 32'h0000_000F;
    step();
    ap_rst_n = 1'b1;
    refresh_mode = 1;
    stub_lat = 3;
    run_txn(0, 1'b0);
    check("single_data_const", rsp_data, 32'h0000_00FF);

    // All four requesting, rsp_ready tied high: strict rotation, no starvation.
    for (int i = 0; i < NREQ; i++) begin
      set_req(i, 1'b1);
      grant_cnt[i] = 0;
    end
    refresh_mode = 0;
    for (int t = 0; t < 8; t++) run_txn(0, 1'b1);
    for (int i = 0; i < NREQ; i++) check("fair_count", grant_cnt[i], 2);
    req_valid = '0;
    rsp_ready = 1'b0;

    // Core finishes in the same cycle it takes start: WAIT is skipped.
    stub_zero = 1'b1;
    refresh_mode = 1;
    set_req(3, 1'b1);
    run_txn(0, 1'b0);
    stub_zero = 1'b0;

    // Response held back 10 cycles while another request waits.
    set_req(1, 1'b1);
    set_req(2, 1'b1);
    run_txn(10, 1'b0);
    run_txn(0, 1'b0);

`ifdef EVEN_ODD_ARB_TIMEOUT_EN
    // Watchdog: core never finishes.
    stub_hang = 1'b1;
    set_req(0, 1'b1);
    #1;
    check("to_grant", req_ready, 4'b0001);
    step();
    req_valid[0] = 1'b0;
    for (int c = 2; c <= 16; c++) begin
      step();
      check("to_not_yet", rsp_valid, 1'b0);
    end
    step();
    check("to_valid", rsp_valid, 1'b1);
    check("to_err", rsp_err, 1'b1);
    check("to_data", rsp_data, '0);
    check("to_start_low", core_start, 1'b0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    model_ptr = 1;
    set_req(1, 1'b1);
    for (int c = 0; c < 5; c++) begin
      step();
      check("to_no_grant", req_ready, '0);
      check("to_idle", busy, 1'b0);
    end
    stub_hang = 1'b0;
    run_txn(0, 1'b0);
`endif

    // Reset during WAIT, then restart with pointer back at 0.
    req_valid = '0;
    set_req(2, 1'b1);
    run_txn(0, 1'b0);
    set_req(1, 1'b1);
    #1;
    got = (req_ready == 4'b0010);
    check("rstw_grant", req_ready, 4'b0010);
    step();
    req_valid[1] = 1'b0;
    step();
    check("rstw_in_wait", dbg_state, ST_WAIT);
    #1;
    ap_rst_n = 1'b0;
    #1;
    check("rstw_start", core_start, 1'b0);
    check("rstw_busy", busy, 1'b0);
    check("rstw_rsp_valid", rsp_valid, 1'b0);
    check("rstw_core_s", core_s, '0);
    set_req(2, 1'b1);
    set_req(3, 1'b1);
    #1;
    check("rstw_req_ready", req_ready, '0);
    step();
    ap_rst_n = 1'b1;
    model_ptr = 0;
    run_txn(0, 1'b0);
    req_valid = '0;

    // Randomized traffic.
    refresh_mode = 2;
    set_req($urandom_range(0, NREQ - 1), 1'b1);
    for (int t = 0; t < 30; t++) begin
      stub_zero = ($urandom_range(0, 4) == 0);
      stub_lat  = $urandom_range(1, 4);
      run_txn($urandom_range(0, 3), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
